// File: rtl/bp_be_fe_cmd_sched.sv
// Back-end scheduler for the FE command channel: arbitrates redirect/fence/ITLB requests
// into a small FIFO and serializes fences. Optional perf counters: BP_BE_FE_CMD_SCHED_PERF_EN.
module bp_be_fe_cmd_sched #(
  parameter int fe_cmd_width_p  = 109,
  parameter int fifo_els_p      = 2,
  parameter int fence_timeout_p = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      redir_v_i,
  input  logic [fe_cmd_width_p-1:0] redir_cmd_i,
  output logic                      redir_yumi_o,
  input  logic                      fence_v_i,
  input  logic [fe_cmd_width_p-1:0] fence_cmd_i,
  output logic                      fence_yumi_o,
  input  logic                      itlb_v_i,
  input  logic [fe_cmd_width_p-1:0] itlb_cmd_i,
  output logic                      itlb_yumi_o,
  input  logic                      flush_i,
  output logic [fe_cmd_width_p-1:0] fe_cmd_o,
  output logic                      fe_cmd_v_o,
  input  logic                      fe_cmd_ready_i,
  input  logic                      fe_cmd_fence_i,
  output logic                      busy_o,
  output logic                      fence_timeout_o
`ifdef BP_BE_FE_CMD_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_stall_full_o,
  output logic [31:0]               perf_stall_fence_o,
  output logic [31:0]               perf_cmds_o
`endif
);

  localparam int ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w = $clog2(fifo_els_p + 1);
  localparam int to_w  = $clog2(fence_timeout_p + 1);

  typedef enum logic [1:0] {IDLE, SEND, FENCE_WAIT} state_e;

  state_e                  state_reg;
  logic [fe_cmd_width_p:0] mem [fifo_els_p];
  logic [ptr_w-1:0]        rd_ptr_reg, wr_ptr_reg;
  logic [ptr_w-1:0]        rd_ptr_next, wr_ptr_next;
  logic [cnt_w-1:0]        count_reg, count_next;
  logic [to_w-1:0]         to_cnt_reg;
  logic                    timeout_reg;

  logic                    empty, full, deq, enq, can_grant;
  logic [fe_cmd_width_p:0] head, enq_data;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == cnt_w'(fifo_els_p));
  assign head       = mem[rd_ptr_reg];
  assign fe_cmd_v_o = !empty && (state_reg != FENCE_WAIT);
  assign fe_cmd_o   = empty ? '0 : head[fe_cmd_width_p-1:0];
  assign deq        = fe_cmd_v_o && fe_cmd_ready_i;
  assign busy_o     = !empty || (state_reg != IDLE);
  assign fence_timeout_o = timeout_reg;

  // A slot freed by this cycle's dequeue may be refilled in the same cycle.
  assign can_grant    = (!full || deq) && (state_reg != FENCE_WAIT) && !flush_i && !reset_i;
  assign redir_yumi_o = can_grant && redir_v_i;
  assign fence_yumi_o = can_grant && fence_v_i && !redir_v_i;
  assign itlb_yumi_o  = can_grant && itlb_v_i && !redir_v_i && !fence_v_i;
  assign enq          = redir_yumi_o || fence_yumi_o || itlb_yumi_o;

  always_comb begin
    enq_data = {1'b0, itlb_cmd_i};
    if (redir_yumi_o)      enq_data = {1'b0, redir_cmd_i};
    else if (fence_yumi_o) enq_data = {1'b1, fence_cmd_i};
  end

  // Flush keeps only a presented head; the write pointer snaps back behind it.
  always_comb begin
    logic [ptr_w-1:0] wr_base;
    logic [cnt_w-1:0] cnt_base;
    wr_base  = wr_ptr_reg;
    cnt_base = count_reg;
    if (flush_i) begin
      wr_base  = fe_cmd_v_o ? rd_ptr_reg + ptr_w'(1) : rd_ptr_reg;
      cnt_base = fe_cmd_v_o ? cnt_w'(1) : '0;
    end
    rd_ptr_next = rd_ptr_reg + ptr_w'(deq);
    wr_ptr_next = wr_base + ptr_w'(enq);
    count_next  = cnt_base - cnt_w'(deq) + cnt_w'(enq);
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr_reg] <= enq_data;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= IDLE;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      case (state_reg)
        IDLE: begin
          if (enq) state_reg <= SEND;
        end
        SEND: begin
          if (deq && head[fe_cmd_width_p]) begin
            state_reg  <= FENCE_WAIT;
            to_cnt_reg <= '0;
          end else if (count_next == '0) begin
            state_reg <= IDLE;
          end
        end
        FENCE_WAIT: begin
          if (!fe_cmd_fence_i) begin
            state_reg <= (count_next != '0) ? SEND : IDLE;
          end else begin
            if (to_cnt_reg != to_w'(fence_timeout_p)) to_cnt_reg <= to_cnt_reg + to_w'(1);
            if (to_cnt_reg == to_w'(fence_timeout_p - 1)) timeout_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef BP_BE_FE_CMD_SCHED_PERF_EN
  logic [31:0] stall_full_reg, stall_fence_reg, cmds_reg;
  logic        any_v;

  assign any_v = redir_v_i || fence_v_i || itlb_v_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_full_reg  <= '0;
      stall_fence_reg <= '0;
      cmds_reg        <= '0;
    end else begin
      if (any_v && full && !deq) stall_full_reg <= stall_full_reg + 32'd1;
      if (state_reg == FENCE_WAIT) stall_fence_reg <= stall_fence_reg + 32'd1;
      if (deq) cmds_reg <= cmds_reg + 32'd1;
    end
  end

  assign perf_stall_full_o  = stall_full_reg;
  assign perf_stall_fence_o = stall_fence_reg;
  assign perf_cmds_o        = cmds_reg;
`endif

endmodule

// File: tb/tb_bp_be_fe_cmd_sched.sv
// Self-checking bench for bp_be_fe_cmd_sched: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_bp_be_fe_cmd_sched;
  localparam int W   = 109;
  localparam int ELS = 2;
  localparam int P   = 64;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         redir_v = 1'b0, fence_v = 1'b0, itlb_v = 1'b0;
  logic [W-1:0] redir_cmd = '0, fence_cmd = '0, itlb_cmd = '0;
  logic         redir_yumi, fence_yumi, itlb_yumi;
  logic         flush = 1'b0;
  logic [W-1:0] fe_cmd;
  logic         fe_cmd_v;
  logic         ready = 1'b0, fence_i = 1'b0;
  logic         busy, timeout;

  bp_be_fe_cmd_sched #(.fe_cmd_width_p(W), .fifo_els_p(ELS), .fence_timeout_p(P)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .redir_v_i(redir_v), .redir_cmd_i(redir_cmd), .redir_yumi_o(redir_yumi),
    .fence_v_i(fence_v), .fence_cmd_i(fence_cmd), .fence_yumi_o(fence_yumi),
    .itlb_v_i(itlb_v), .itlb_cmd_i(itlb_cmd), .itlb_yumi_o(itlb_yumi),
    .flush_i(flush), .fe_cmd_o(fe_cmd), .fe_cmd_v_o(fe_cmd_v),
    .fe_cmd_ready_i(ready), .fe_cmd_fence_i(fence_i),
    .busy_o(busy), .fence_timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of {is_fence, cmd}, a fence-wait flag and a timeout counter.
  logic [W:0]   q[$];
  logic [W-1:0] acc[$];
  bit           fw = 0, to = 0;
  int           cnt = 0;
  bit           got_r, got_f, got_i;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_cmd();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Called just after a negedge with inputs set; checks, clocks, updates the model.
  task automatic step();
    logic [W:0]   h;
    logic [W-1:0] e_cmd;
    bit e_v, deq, can, gr, gf, gi;
    #1;
    e_v   = (q.size() > 0) && !fw;
    e_cmd = (q.size() > 0) ? q[0][W-1:0] : '0;
    deq   = e_v && ready;
    can   = ((q.size() < ELS) || deq) && !fw && !flush && !reset_i;
    gr    = can && redir_v;
    gf    = can && fence_v && !redir_v;
    gi    = can && itlb_v && !redir_v && !fence_v;
    chk("redir_yumi", redir_yumi, gr);
    chk("fence_yumi", fence_yumi, gf);
    chk("itlb_yumi", itlb_yumi, gi);
    chk("fe_cmd_v", fe_cmd_v, e_v);
    if (e_v) chk("fe_cmd", fe_cmd, e_cmd);
    chk("busy", busy, (q.size() > 0) || fw);
    chk("timeout", timeout, to);
    got_r = redir_yumi; got_f = fence_yumi; got_i = itlb_yumi;
    if (deq && !reset_i) acc.push_back(e_cmd);
    @(posedge clk);
    if (reset_i) begin
      q.delete(); fw = 0; to = 0; cnt = 0;
    end else begin
      if (fw) begin
        if (!fence_i) fw = 0;
        else begin
          if (cnt < P) cnt++;
          if (cnt == P) to = 1;
        end
      end
      if (flush) begin
        if (e_v) begin h = q[0]; q.delete(); q.push_back(h); end
        else q.delete();
      end
      if (deq) begin
        h = q.pop_front();
        if (h[W]) begin fw = 1; cnt = 0; end
      end
      if (gr) q.push_back({1'b0, redir_cmd});
      if (gf) q.push_back({1'b1, fence_cmd});
      if (gi) q.push_back({1'b0, itlb_cmd});
    end
    @(negedge clk);
  endtask

  task automatic drop_granted();
    if (got_r) redir_v = 1'b0;
    if (got_f) fence_v = 1'b0;
    if (got_i) itlb_v = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    chk("rst_v", fe_cmd_v, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_cmd", fe_cmd, '0);

    // Single redirect: yumi same cycle, presented next cycle.
    redir_v = 1'b1; redir_cmd = W'(12'h00A);
    step();
    chk("t1_yumi", got_r, 1'b1);
    redir_v = 1'b0;
    chk("t1_v", fe_cmd_v, 1'b1);
    chk("t1_cmd", fe_cmd, W'(12'h00A));
    step();
    chk("t1_busy_held", busy, 1'b1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t1_busy_done", busy, 1'b0);

    // Three simultaneous requesters, FE stalled then released.
    acc.delete();
    redir_v = 1'b1; redir_cmd = W'(1);
    fence_v = 1'b1; fence_cmd = W'(2);
    itlb_v  = 1'b1; itlb_cmd  = W'(3);
    for (int i = 0; i < 3; i++) begin step(); drop_granted(); end
    chk("t2_itlb_pending", itlb_v, 1'b1);
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); drop_granted(); end
    ready = 1'b0;
    chk("t2_acc_n", W'(acc.size()), W'(3));
    if (acc.size() == 3) begin
      chk("t2_order0", acc[0], W'(1));
      chk("t2_order1", acc[1], W'(2));
      chk("t2_order2", acc[2], W'(3));
    end

    // Fence held by FE for 5 cycles; the queued ITLB fill waits behind it.
    fence_v = 1'b1; fence_cmd = W'(8'h55);
    itlb_v  = 1'b1; itlb_cmd  = W'(8'h66);
    step(); drop_granted();
    step(); drop_granted();
    ready = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_v_hold", fe_cmd_v, 1'b0);
      fence_i = 1'b1;
      step();
    end
    fence_i = 1'b0;
    chk("t3_v_fall", fe_cmd_v, 1'b0);
    step();
    chk("t3_v_after", fe_cmd_v, 1'b1);
    chk("t3_cmd_after", fe_cmd, W'(8'h66));
    step();
    ready = 1'b0;

    // Flush with two entries: head survives unchanged, second entry dropped.
    redir_v = 1'b1; redir_cmd = W'(8'h11);
    step();
    redir_cmd = W'(8'h22);
    step();
    redir_v = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_v", fe_cmd_v, 1'b1);
    chk("t4_cmd", fe_cmd, W'(8'h11));
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t4_busy", busy, 1'b0);
    chk("t4_v_empty", fe_cmd_v, 1'b0);

    // Fence acknowledged but fe_cmd_fence_i stuck high.
    fence_v = 1'b1; fence_cmd = W'(8'h77);
    step();
    fence_v = 1'b0; ready = 1'b1;
    step();
    ready = 1'b0; fence_i = 1'b1;
    for (int i = 0; i < P; i++) begin
      chk("t5_to_low", timeout, 1'b0);
      step();
    end
    chk("t5_to_set", timeout, 1'b1);
    repeat (3) step();
    chk("t5_to_sticky", timeout, 1'b1);
    fence_i = 1'b0;
    step();
    chk("t5_to_after_exit", timeout, 1'b1);

    // Reset while in fence wait with a full FIFO.
    fence_v = 1'b1; fence_cmd = W'(8'h99);
    step(); drop_granted();
    redir_v = 1'b1; redir_cmd = W'(8'hA1);
    step(); drop_granted();
    itlb_v = 1'b1; itlb_cmd = W'(8'hB2); ready = 1'b1;
    step(); drop_granted();
    chk("t6_itlb_in", got_i, 1'b1);
    ready = 1'b0; fence_i = 1'b1;
    step();
    chk("t6_full", busy, 1'b1);
    reset_i = 1'b1; fence_i = 1'b0;
    step();
    reset_i = 1'b0;
    chk("t6_v", fe_cmd_v, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_timeout", timeout, 1'b0);
    chk("t6_cmd", fe_cmd, '0);
    step();

    // Random traffic with holding requesters.
    for (int n = 0; n < 2000; n++) begin
      if (!redir_v && $urandom_range(0, 99) < 15) begin redir_v = 1'b1; redir_cmd = rnd_cmd(); end
      if (!fence_v && $urandom_range(0, 99) < 10) begin fence_v = 1'b1; fence_cmd = rnd_cmd(); end
      if (!itlb_v  && $urandom_range(0, 99) < 20) begin itlb_v  = 1'b1; itlb_cmd  = rnd_cmd(); end
      ready   = ($urandom_range(0, 99) < 65);
      flush   = ($urandom_range(0, 99) < 5);
      fence_i = ($urandom_range(0, 99) < 45);
      reset_i = ($urandom_range(0, 999) < 3);
      step();
      drop_granted();
      if (reset_i) begin redir_v = 1'b0; fence_v = 1'b0; itlb_v = 1'b0; end
    end
    reset_i = 1'b0; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
